// File: rtl/vga_timing_pkg.sv
// 640x480@60 timing constants and helpers shared by the sync generator and the renderer.
package vga_timing_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    localparam int H_SYNC_START = DEF_H_ACTIVE + DEF_H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + DEF_H_SYNC - 1;
    localparam int V_SYNC_START = DEF_V_ACTIVE + DEF_V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + DEF_V_SYNC - 1;

    localparam logic DEF_SYNC_ACTIVE = 1'b0;

    // ROM read plus RGB output register in the renderer
    localparam int RENDER_LATENCY = 2;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic display_on;
    } sync_bits_t;

    function automatic logic sync_level(input logic in_pulse, input logic active);
        return in_pulse ? active : ~active;
    endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Scan position and DAC strobes from the VGA timing generator.
interface vga_sync_gen_if;

  logic signed [31:0] X;
  logic signed [31:0] Y;
  logic               display_on;
  logic               frame_end;
  logic               hsync;
  logic               vsync;
  logic               blank_n;

  modport master (output X, Y, display_on, frame_end, hsync, vsync, blank_n);
  modport slave  (input  X, Y, display_on, frame_end, hsync, vsync, blank_n);

endinterface

// File: rtl/vga_sync_gen_sync_delay_line.sv
// Async-reset shift register of DEPTH stages; DEPTH=0 passes d straight through.
module sync_delay_line #(
  parameter int               WIDTH   = 3,
  parameter int               DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             VGA_clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_bypass
      wire unused_bypass = ^{VGA_clk, rst, RST_VAL};
      assign q = d;
    end else begin : g_chain
      logic [WIDTH-1:0] stage_reg [DEPTH];

      always_ff @(posedge VGA_clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < DEPTH; i++) stage_reg[i] <= RST_VAL;
        end else begin
          stage_reg[0] <= d;
          for (int i = 1; i < DEPTH; i++) stage_reg[i] <= stage_reg[i-1];
        end
      end

      assign q = stage_reg[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_sync_gen.sv
// VGA scan counters with registered position decodes and sync/blank delayed to match the renderer.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE    = DEF_H_ACTIVE,
  parameter int   H_FP        = DEF_H_FP,
  parameter int   H_SYNC      = DEF_H_SYNC,
  parameter int   H_BP        = DEF_H_BP,
  parameter int   V_ACTIVE    = DEF_V_ACTIVE,
  parameter int   V_FP        = DEF_V_FP,
  parameter int   V_SYNC      = DEF_V_SYNC,
  parameter int   V_BP        = DEF_V_BP,
  parameter logic SYNC_ACTIVE = DEF_SYNC_ACTIVE,
  parameter int   PIPE_DELAY  = RENDER_LATENCY
) (
  input logic            VGA_clk,
  input logic            rst,
  vga_sync_gen_if.master vga
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW    = $clog2(H_TOT);
  localparam int VW    = $clog2(V_TOT);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOT - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOT - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [HW-1:0] h_cnt_reg, h_cnt_next;
  logic [VW-1:0] v_cnt_reg, v_cnt_next;
  logic          display_on_reg, frame_end_reg, hsync_reg, vsync_reg;
  sync_bits_t    dly_in, dly_out;

  always_comb begin
    h_cnt_next = h_cnt_reg + 1'b1;
    v_cnt_next = v_cnt_reg;
    if (h_cnt_reg == H_LAST) begin
      h_cnt_next = '0;
      v_cnt_next = (v_cnt_reg == V_LAST) ? '0 : v_cnt_reg + 1'b1;
    end
  end

  // Reset parks the counters on the last pixel so the first edge lands on (0,0).
  // Decodes look at the next-state counters so they line up with X/Y.
  always_ff @(posedge VGA_clk or posedge rst) begin
    if (rst) begin
      h_cnt_reg      <= H_LAST;
      v_cnt_reg      <= V_LAST;
      display_on_reg <= 1'b0;
      frame_end_reg  <= 1'b0;
      hsync_reg      <= ~SYNC_ACTIVE;
      vsync_reg      <= ~SYNC_ACTIVE;
    end else begin
      h_cnt_reg      <= h_cnt_next;
      v_cnt_reg      <= v_cnt_next;
      display_on_reg <= (h_cnt_next < H_ACT) && (v_cnt_next < V_ACT);
      frame_end_reg  <= (h_cnt_next == '0) && (v_cnt_next == V_ACT);
      hsync_reg      <= sync_level((h_cnt_next >= HS_START) && (h_cnt_next <= HS_END),
                                   SYNC_ACTIVE);
      vsync_reg      <= sync_level((v_cnt_next >= VS_START) && (v_cnt_next <= VS_END),
                                   SYNC_ACTIVE);
    end
  end

  assign dly_in = '{hsync: hsync_reg, vsync: vsync_reg, display_on: display_on_reg};

  sync_delay_line #(
    .WIDTH   (3),
    .DEPTH   (PIPE_DELAY),
    .RST_VAL ({~SYNC_ACTIVE, ~SYNC_ACTIVE, 1'b0})
  ) u_sync_delay_line (
    .VGA_clk (VGA_clk),
    .rst     (rst),
    .d       (dly_in),
    .q       (dly_out)
  );

  assign vga.X          = 32'(h_cnt_reg);
  assign vga.Y          = 32'(v_cnt_reg);
  assign vga.display_on = display_on_reg;
  assign vga.frame_end  = frame_end_reg;
  assign vga.hsync      = dly_out.hsync;
  assign vga.vsync      = dly_out.vsync;
  assign vga.blank_n    = dly_out.display_on;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Four timing generators (default, zero delay, active-high/320 wide, reduced frame) against a reference model.
module tb_vga_sync_gen;

  localparam int N = 4;
  localparam int   P_HA [N] = '{640, 640, 320, 64};
  localparam int   P_HF [N] = '{16, 16, 16, 8};
  localparam int   P_HS [N] = '{96, 96, 96, 16};
  localparam int   P_HB [N] = '{48, 48, 48, 8};
  localparam int   P_VA [N] = '{480, 480, 480, 48};
  localparam int   P_VF [N] = '{10, 10, 10, 4};
  localparam int   P_VS [N] = '{2, 2, 2, 2};
  localparam int   P_VB [N] = '{33, 33, 33, 6};
  localparam logic P_SA [N] = '{1'b0, 1'b0, 1'b1, 1'b0};
  localparam int   P_PD [N] = '{2, 0, 0, 2};
  localparam int SMALL_FRAME = 96 * 60;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic signed [31:0] x_s [N];
  logic signed [31:0] y_s [N];
  logic disp_s [N], fe_s [N], hs_s [N], vs_s [N], bn_s [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_dut
    vga_sync_gen_if vif ();
    vga_sync_gen #(
      .H_ACTIVE(P_HA[gi]), .H_FP(P_HF[gi]), .H_SYNC(P_HS[gi]), .H_BP(P_HB[gi]),
      .V_ACTIVE(P_VA[gi]), .V_FP(P_VF[gi]), .V_SYNC(P_VS[gi]), .V_BP(P_VB[gi]),
      .SYNC_ACTIVE(P_SA[gi]), .PIPE_DELAY(P_PD[gi])
    ) u_dut (.VGA_clk(clk), .rst(rst), .vga(vif));
    assign x_s[gi] = vif.X;           assign y_s[gi] = vif.Y;
    assign disp_s[gi] = vif.display_on; assign fe_s[gi] = vif.frame_end;
    assign hs_s[gi] = vif.hsync;      assign vs_s[gi] = vif.vsync;
    assign bn_s[gi] = vif.blank_n;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reset-state (phase 0) and first-edge (phase 1) vectors for every instance
  typedef struct {
    int inst; int phase; int x; int y;
    logic disp; logic fe; logic hs; logic vs; logic bn;
  } vec_t;
  vec_t vecs [2*N];

  task automatic build_table();
    for (int i = 0; i < N; i++) begin
      int ht, vt;
      ht = P_HA[i] + P_HF[i] + P_HS[i] + P_HB[i];
      vt = P_VA[i] + P_VF[i] + P_VS[i] + P_VB[i];
      vecs[2*i]   = '{i, 0, ht - 1, vt - 1, 1'b0, 1'b0, ~P_SA[i], ~P_SA[i], 1'b0};
      vecs[2*i+1] = '{i, 1, 0, 0, 1'b1, 1'b0, ~P_SA[i], ~P_SA[i], (P_PD[i] == 0)};
    end
  endtask

  task automatic apply_table(input int phase);
    for (int k = 0; k < 2*N; k++) begin
      if (vecs[k].phase == phase) begin
        int i, e0;
        i = vecs[k].inst;
        e0 = n_errors;
        chk($sformatf("vec%0d.u%0d.X", k, i), x_s[i], vecs[k].x);
        chk($sformatf("vec%0d.u%0d.Y", k, i), y_s[i], vecs[k].y);
        chk($sformatf("vec%0d.u%0d.display_on", k, i), disp_s[i], vecs[k].disp);
        chk($sformatf("vec%0d.u%0d.frame_end", k, i), fe_s[i], vecs[k].fe);
        chk($sformatf("vec%0d.u%0d.hsync", k, i), hs_s[i], vecs[k].hs);
        chk($sformatf("vec%0d.u%0d.vsync", k, i), vs_s[i], vecs[k].vs);
        chk($sformatf("vec%0d.u%0d.blank_n", k, i), bn_s[i], vecs[k].bn);
        $display("vector %0d inst %0d phase %0d: X=%0d Y=%0d, %0d new errors",
                 k, i, phase, x_s[i], y_s[i], n_errors - e0);
      end
    end
  endtask

  // Scoreboard: undelayed {hsync, vsync, display_on} expectations queued per instance,
  // popped PIPE_DELAY cycles later against the delayed outputs.
  logic [2:0] sb_q [N][$];
  bit mon_en = 1'b0;
  int cyc = 0;

  task automatic sb_init();
    for (int i = 0; i < N; i++) begin
      sb_q[i].delete();
      for (int k = 0; k < P_PD[i]; k++) sb_q[i].push_back({~P_SA[i], ~P_SA[i], 1'b0});
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      cyc++;
      for (int i = 0; i < N; i++) begin
        int ht, vt, p, x, y;
        logic e_d, e_fe, e_hs, e_vs;
        logic [2:0] t;
        ht = P_HA[i] + P_HF[i] + P_HS[i] + P_HB[i];
        vt = P_VA[i] + P_VF[i] + P_VS[i] + P_VB[i];
        p = (cyc - 1) % (ht * vt);
        x = p % ht;
        y = p / ht;
        e_d  = (x < P_HA[i]) && (y < P_VA[i]);
        e_fe = (x == 0) && (y == P_VA[i]);
        e_hs = ((x >= P_HA[i] + P_HF[i]) && (x < P_HA[i] + P_HF[i] + P_HS[i])) ? P_SA[i] : ~P_SA[i];
        e_vs = ((y >= P_VA[i] + P_VF[i]) && (y < P_VA[i] + P_VF[i] + P_VS[i])) ? P_SA[i] : ~P_SA[i];
        chk($sformatf("u%0d.X@%0d", i, cyc), x_s[i], x);
        chk($sformatf("u%0d.Y@%0d", i, cyc), y_s[i], y);
        chk($sformatf("u%0d.display_on@%0d", i, cyc), disp_s[i], e_d);
        chk($sformatf("u%0d.frame_end@%0d", i, cyc), fe_s[i], e_fe);
        sb_q[i].push_back({e_hs, e_vs, e_d});
        t = sb_q[i].pop_front();
        chk($sformatf("u%0d.hsync@%0d", i, cyc), hs_s[i], t[2]);
        chk($sformatf("u%0d.vsync@%0d", i, cyc), vs_s[i], t[1]);
        chk($sformatf("u%0d.blank_n@%0d", i, cyc), bn_s[i], t[0]);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int disp_fall_x, bn_fall_x, hs_fall_x, wrap0_cnt, wrap0_bad;
    int hs1_low, hs1_first, hs1_last, hs2_high, hs2_first, x2_max;
    int fe3_cnt, fe3_x, fe3_y, fe3_c1, fe3_c2, vs3_low, wrap3_cnt, wrap3_bad;
    logic prev_disp0, prev_bn0, prev_hs0;
    int prev_x0, prev_y0, prev_x3, prev_y3, cnt;
    bit found;

    disp_fall_x = -1; bn_fall_x = -1; hs_fall_x = -1; wrap0_cnt = 0; wrap0_bad = 0;
    hs1_low = 0; hs1_first = -1; hs1_last = -1; hs2_high = 0; hs2_first = -1; x2_max = 0;
    fe3_cnt = 0; fe3_x = -1; fe3_y = -1; fe3_c1 = -1; fe3_c2 = -1; vs3_low = 0;
    wrap3_cnt = 0; wrap3_bad = 0;

    rst = 1'b1;
    build_table();
    repeat (5) @(posedge clk);
    @(negedge clk);
    apply_table(0);
    #1 rst = 1'b0;
    sb_init();
    cyc = 0;
    mon_en = 1'b1;
    @(negedge clk);
    apply_table(1);

    // Line, frame and delay-alignment run
    prev_disp0 = 1'b0; prev_bn0 = 1'b0; prev_hs0 = 1'b1;
    prev_x0 = 799; prev_y0 = 524; prev_x3 = 95; prev_y3 = 59;
    for (int c = 1; c <= 2*SMALL_FRAME + 1; c++) begin
      if (c > 1) @(negedge clk);
      if (prev_disp0 && !disp_s[0] && disp_fall_x < 0) disp_fall_x = x_s[0];
      if (prev_bn0 && !bn_s[0] && bn_fall_x < 0) bn_fall_x = x_s[0];
      if (prev_hs0 && !hs_s[0] && hs_fall_x < 0) hs_fall_x = x_s[0];
      if (c > 1 && prev_x0 == 799) begin
        wrap0_cnt++;
        if (x_s[0] != 0 || y_s[0] != prev_y0 + 1) wrap0_bad++;
      end
      if (c <= 800 && !hs_s[1]) begin
        hs1_low++;
        if (hs1_first < 0) hs1_first = x_s[1];
        hs1_last = x_s[1];
      end
      if (c <= 480 && hs_s[2]) begin
        hs2_high++;
        if (hs2_first < 0) hs2_first = x_s[2];
      end
      if (x_s[2] > x2_max) x2_max = x_s[2];
      if (fe_s[3]) begin
        if (c <= SMALL_FRAME) begin fe3_cnt++; fe3_x = x_s[3]; fe3_y = y_s[3]; end
        if (fe3_c1 < 0) fe3_c1 = c; else if (fe3_c2 < 0) fe3_c2 = c;
      end
      if (c <= SMALL_FRAME && !vs_s[3]) vs3_low++;
      if (c > 1 && prev_x3 == 95 && prev_y3 == 59) begin
        wrap3_cnt++;
        if (x_s[3] != 0 || y_s[3] != 0) wrap3_bad++;
      end
      prev_disp0 = disp_s[0]; prev_bn0 = bn_s[0]; prev_hs0 = hs_s[0];
      prev_x0 = x_s[0]; prev_y0 = y_s[0]; prev_x3 = x_s[3]; prev_y3 = y_s[3];
    end

    chk("display_on_fall_x", disp_fall_x, 640);
    chk("blank_n_fall_x_delay2", bn_fall_x, 642);
    chk("hsync_fall_x_delay2", hs_fall_x, 658);
    chk("line_wraps", wrap0_cnt, 14);
    chk("line_wrap_bad", wrap0_bad, 0);
    $display("line timing: display_on falls at %0d, blank_n at %0d, hsync at %0d", disp_fall_x, bn_fall_x, hs_fall_x);
    chk("hsync_low_cycles", hs1_low, 96);
    chk("hsync_low_first_x", hs1_first, 656);
    chk("hsync_low_last_x", hs1_last, 751);
    $display("undelayed hsync: %0d low cycles from X=%0d to X=%0d", hs1_low, hs1_first, hs1_last);
    chk("alt_hsync_high_cycles", hs2_high, 96);
    chk("alt_hsync_high_first_x", hs2_first, 336);
    chk("alt_x_max", x2_max, 479);
    $display("active-high 320 wide: %0d high cycles from X=%0d, max X=%0d", hs2_high, hs2_first, x2_max);
    chk("frame_end_count", fe3_cnt, 1);
    chk("frame_end_x", fe3_x, 0);
    chk("frame_end_y", fe3_y, 48);
    chk("frame_period", fe3_c2 - fe3_c1, SMALL_FRAME);
    chk("vsync_low_cycles", vs3_low, 2 * 96);
    chk("frame_wraps", wrap3_cnt, 2);
    chk("frame_wrap_bad", wrap3_bad, 0);
    $display("frame: frame_end at (%0d,%0d), period %0d, vsync low %0d cycles", fe3_x, fe3_y, fe3_c2 - fe3_c1, vs3_low);

    // Mid-frame asynchronous reset
    found = 1'b0;
    for (int k = 0; k < 7000 && !found; k++) begin
      @(negedge clk);
      if (x_s[3] == 30 && y_s[3] == 20) found = 1'b1;
    end
    chk("wait_pos_30_20", found, 1);
    #1 mon_en = 1'b0;
    rst = 1'b1;
    #1 apply_table(0);
    @(negedge clk);
    #1 rst = 1'b0;
    sb_init();
    cyc = 0;
    mon_en = 1'b1;
    @(negedge clk);
    chk("restart_x", x_s[3], 0);
    chk("restart_y", y_s[3], 0);
    found = 1'b0;
    cnt = 0;
    for (int k = 0; k < 6000 && !found; k++) begin
      @(negedge clk);
      cnt++;
      if (fe_s[3]) found = 1'b1;
    end
    chk("frame_end_after_reset_seen", found, 1);
    chk("frame_end_after_reset_cycles", cnt, 48 * 96);
    $display("mid-frame reset: frame_end %0d cycles after restart", cnt);

    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

VGA timing generator for the 640x480@60 display path, running on VGA_clk (25.175 MHz nominal). Produces the scan position X/Y and display_on consumed by the sprite/pipe renderer, and the hsync/vsync/blank_n strobes for the DAC. Sync and blank are delayed by a programmable number of cycles so that they reach the DAC in step with the renderer's registered RGB, which lags X/Y by the ROM read plus the output register.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (cycles)
- H_SYNC, 96, hsync pulse width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width
- V_BP, 33, vertical back porch
- SYNC_ACTIVE, 0, asserted level of hsync/vsync (0 = active-low)
- PIPE_DELAY, 2, cycles of delay on hsync/vsync/blank_n relative to X/Y; legal range 0..7

Ports:
- VGA_clk  in  1  pixel clock
- rst  in  1  reset; asynchronous, active-high
- X  out  32 signed  horizontal counter, 0..H_TOTAL-1
- Y  out  32 signed  vertical counter, 0..V_TOTAL-1
- display_on  out  1  high when X<H_ACTIVE and Y<V_ACTIVE; aligned with X/Y
- frame_end  out  1  one-cycle pulse when (X,Y) = (0,V_ACTIVE); aligned with X/Y
- hsync  out  1  horizontal sync, delayed by PIPE_DELAY
- vsync  out  1  vertical sync, delayed by PIPE_DELAY
- blank_n  out  1  display_on delayed by PIPE_DELAY

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- X increments every cycle. When X = H_TOTAL-1, the next value of X is 0 and Y increments.
- When Y = V_TOTAL-1 and X = H_TOTAL-1, the next value of both X and Y is 0.
- The counters are unsigned internally. X and Y are zero-extended to 32 bits and never go negative.
- Undelayed hsync is asserted (= SYNC_ACTIVE) for H_ACTIVE+H_FP ≤ X ≤ H_ACTIVE+H_FP+H_SYNC-1, i.e. 656..751. Otherwise it is at ~SYNC_ACTIVE.
- Undelayed vsync is asserted for V_ACTIVE+V_FP ≤ Y ≤ V_ACTIVE+V_FP+V_SYNC-1, i.e. 490..491, for the whole of each of those lines.
- display_on and frame_end are registered and decoded from the next-state counter values, so they always correspond to the X/Y presented in the same cycle.
- frame_end marks the start of vertical blanking. Game logic uses it to latch the bird and pipe positions for the next frame.
- Delay line: {hsync, vsync, display_on} pass through a PIPE_DELAY-deep register chain.
  - With PIPE_DELAY = 0 the chain is bypassed: the outputs are the undelayed registered values.

## Timing
- Reset values:
  - X = H_TOTAL-1 (799), Y = V_TOTAL-1 (524).
  - display_on = 0, frame_end = 0.
  - hsync = vsync = ~SYNC_ACTIVE (1 at default).
  - blank_n = 0.
  - Every delay-line stage resets to the inactive levels.
- First rising edge after rst deasserts: X=0, Y=0, display_on=1. There is no partial first frame.
- rst asserted mid-frame: all outputs take their reset values immediately (asynchronous). Counting restarts from (0,0) on the first edge after release.
- blank_n at cycle n equals display_on at cycle n-PIPE_DELAY. The same relationship holds for hsync and vsync against their undelayed decodes.
- Frame period is exactly H_TOTAL*V_TOTAL = 420000 cycles. The hsync period is exactly 800 cycles, including across the frame wrap.

## Structure
- Package vga_timing_pkg holds:
  - the 640x480@60 default constants, plus derived H_TOTAL and V_TOTAL;
  - the sync-start/sync-end localparams;
  - the RENDER_LATENCY constant (2), used as the default for PIPE_DELAY and shared with the renderer.
- One sub-module: sync_delay_line, parameters WIDTH and DEPTH, with an async-reset shift register and a DEPTH=0 bypass. It is instantiated with WIDTH=3 for {hsync, vsync, display_on}.

## Test plan
- Reset/release: hold rst for 5 cycles, then release.
  - While in reset: X=799, Y=524, blank_n=0, hsync=vsync=1.
  - Next edge after release: X=0, Y=0, display_on=1.
- Line timing: run 2 lines.
  - Undelayed hsync is low for X = 656..751 only (96 cycles).
  - display_on falls at X=640.
  - X wraps 799→0 and Y increments by 1 on the same edge.
- Frame wrap: run one full frame.
  - frame_end pulses exactly once, at (0,480).
  - Undelayed vsync is low on lines 490 and 491 only (1600 cycles).
  - (799,524) is followed by (0,0). Total frame is 420000 cycles.
- Delay alignment:
  - With PIPE_DELAY=2, blank_n falls 2 cycles after display_on falls, i.e. when X=642; hsync falls when X=658.
  - With PIPE_DELAY=0, both strobes track the undelayed values cycle-for-cycle.
- Mid-frame reset: assert rst at (300,200) for 1 cycle.
  - Outputs go to their reset values asynchronously.
  - After release the count restarts at (0,0), and the next frame_end arrives 480*800 cycles later.
- Non-default parameters: SYNC_ACTIVE=1 and H_ACTIVE=320. hsync is high for X = 336..431, and H_TOTAL = 480.
